// File: rtl/parking_pkg.sv
// Shared types and constants for the parking entry gate and occupancy counter.
// The gate state enum and car class are common to both blocks.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BADGE,
        DECIDE,
        REJECT,
        OPEN,
        PASSING,
        CLOSE
    } gate_state_t;

    typedef enum logic {
        VISITOR = 1'b0,
        UNI     = 1'b1
    } car_class_t;

    localparam int unsigned UNI_CAPACITY   = 500;
    localparam int unsigned TOTAL_CAPACITY = 700;
    localparam int unsigned BASE_FREE      = 200;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/parking_entry_gate_timer.sv
// gate_timer: loadable saturating up-counter with clear, enable and a
// terminal-count compare against a run-time selectable value.
module gate_timer #(
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned SAT_VAL = (1 << CNT_W) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(SAT_VAL);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count < SAT)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == tc_val);

endmodule

// File: rtl/parking_entry_gate.sv
// Entry-barrier controller: one vehicle at a time, badge classify, vacancy check,
// barrier sequencing. Optional open-timeout via `PARKING_GATE_TIMEOUT_EN.
module parking_entry_gate
    import parking_pkg::*;
#(
    parameter int unsigned BADGE_WAIT   = 16,
    parameter int unsigned OPEN_TIMEOUT = 1000,
    parameter int unsigned CNT_W        = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic car_detect,
    input  logic badge_valid,
    input  logic badge_is_uni,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    input  logic pass_sensor,
    output logic barrier_open,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic reject,
    output logic busy,
    output logic gate_timeout
);

    localparam logic [CNT_W-1:0] BADGE_TC = CNT_W'(BADGE_WAIT - 1);

    gate_state_t      state;
    car_class_t       car_class;
    logic             timer_clr;
    logic             timer_en;
    logic             timer_tc;
    logic [CNT_W-1:0] timer_tc_val;
    logic             vacancy;

    // The timer is cleared in IDLE and DECIDE so it starts from 0 in both WAIT_BADGE and OPEN.
    assign timer_clr = (state == IDLE) || (state == DECIDE);

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] OPEN_TC = CNT_W'(OPEN_TIMEOUT - 1);
    assign timer_en     = (state == WAIT_BADGE) || (state == OPEN);
    assign timer_tc_val = (state == OPEN) ? OPEN_TC : BADGE_TC;
`else
    assign timer_en     = (state == WAIT_BADGE);
    assign timer_tc_val = BADGE_TC;
    assign gate_timeout = 1'b0;
`endif

    gate_timer #(
        .CNT_W   (CNT_W),
        .SAT_VAL (max_u(BADGE_WAIT, OPEN_TIMEOUT))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (timer_clr),
        .en       (timer_en),
        .load     (1'b0),
        .load_val ('0),
        .tc_val   (timer_tc_val),
        .tc       (timer_tc)
    );

    assign vacancy = (car_class == UNI) ? uni_is_vacated_space : is_vacated_space;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            car_class          <= VISITOR;
            barrier_open       <= 1'b0;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            reject             <= 1'b0;
            busy               <= 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
            gate_timeout       <= 1'b0;
`endif
        end else begin
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            reject             <= 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
            gate_timeout       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (car_detect) begin
                        state <= WAIT_BADGE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_BADGE: begin
                    if (!car_detect) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (badge_valid) begin
                        car_class <= car_class_t'(badge_is_uni);
                        state     <= DECIDE;
                    end else if (timer_tc) begin
                        car_class <= VISITOR;
                        state     <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (vacancy) begin
                        state        <= OPEN;
                        barrier_open <= 1'b1;
                    end else begin
                        state  <= REJECT;
                        reject <= 1'b1;
                    end
                end
                REJECT: begin
                    if (!car_detect) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                OPEN: begin
                    if (pass_sensor) begin
                        state <= PASSING;
`ifdef PARKING_GATE_TIMEOUT_EN
                    end else if (timer_tc) begin
                        state        <= REJECT;
                        barrier_open <= 1'b0;
                        gate_timeout <= 1'b1;
`endif
                    end
                end
                PASSING: begin
                    if (!pass_sensor) begin
                        state              <= CLOSE;
                        barrier_open       <= 1'b0;
                        car_entered        <= 1'b1;
                        is_uni_car_entered <= (car_class == UNI);
                    end
                end
                CLOSE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    barrier_open <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_entry_gate.sv
// Self-checking bench for parking_entry_gate: vector table, hand-written corner
// sequences, and randomized vehicles checked against a transaction-level model.
module tb_parking_entry_gate;

    localparam int BW = 16;
    localparam int OT = 20;

    logic clk = 1'b0;
    logic reset, car_detect, badge_valid, badge_is_uni;
    logic uni_is_vacated_space, is_vacated_space, pass_sensor;
    logic barrier_open, car_entered, is_uni_car_entered, reject, busy, gate_timeout;

    int total = 0;
    int bad   = 0;

    int ent_cnt = 0;
    int rej_cnt = 0;
    int stray   = 0;
    bit ent_uni = 1'b0;

    always #5 clk = ~clk;

    parking_entry_gate #(
        .BADGE_WAIT   (BW),
        .OPEN_TIMEOUT (OT),
        .CNT_W        (10)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .car_detect           (car_detect),
        .badge_valid          (badge_valid),
        .badge_is_uni         (badge_is_uni),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .pass_sensor          (pass_sensor),
        .barrier_open         (barrier_open),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .reject               (reject),
        .busy                 (busy),
        .gate_timeout         (gate_timeout)
    );

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (car_entered) begin
            ent_cnt++;
            ent_uni = is_uni_car_entered;
        end
        if (reject) rej_cnt++;
        if (!car_entered && is_uni_car_entered) stray++;
    end

    typedef struct {
        logic [6:0] in;   // {reset, car_detect, badge_valid, badge_is_uni, uni_vac, vac, pass}
        logic [5:0] exp;  // {barrier_open, car_entered, is_uni, reject, busy, gate_timeout}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [6:0] in, input logic [5:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [5:0] outs();
        return {barrier_open, car_entered, is_uni_car_entered, reject, busy, gate_timeout};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick(input logic [6:0] in);
        {reset, car_detect, badge_valid, badge_is_uni,
         uni_is_vacated_space, is_vacated_space, pass_sensor} = in;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        // Uni car, pass high 3 cycles
        tbl.push_back(mk(7'b1000000, 6'b000000));
        tbl.push_back(mk(7'b0100000, 6'b000010));
        tbl.push_back(mk(7'b0111000, 6'b000010));
        tbl.push_back(mk(7'b0100100, 6'b100010));
        tbl.push_back(mk(7'b0100101, 6'b100010));
        tbl.push_back(mk(7'b0000001, 6'b100010));
        tbl.push_back(mk(7'b0000001, 6'b100010));
        tbl.push_back(mk(7'b0000000, 6'b011010));
        tbl.push_back(mk(7'b0000000, 6'b000000));
        // Uni car, lot full for uni
        tbl.push_back(mk(7'b0100000, 6'b000010));
        tbl.push_back(mk(7'b0111000, 6'b000010));
        tbl.push_back(mk(7'b0100010, 6'b000110));
        tbl.push_back(mk(7'b0100000, 6'b000010));
        tbl.push_back(mk(7'b0100000, 6'b000010));
        tbl.push_back(mk(7'b0000000, 6'b000000));
        // Car leaves on the badge cycle; IDLE ignores badge/pass
        tbl.push_back(mk(7'b0100000, 6'b000010));
        tbl.push_back(mk(7'b0011000, 6'b000000));
        tbl.push_back(mk(7'b0011001, 6'b000000));
        // Visitor badge, reset while passing
        tbl.push_back(mk(7'b0100000, 6'b000010));
        tbl.push_back(mk(7'b0110000, 6'b000010));
        tbl.push_back(mk(7'b0100010, 6'b100010));
        tbl.push_back(mk(7'b0000001, 6'b100010));
        tbl.push_back(mk(7'b1000001, 6'b000000));
        tbl.push_back(mk(7'b0000000, 6'b000000));
        // Visitor badge uses the visitor flag only
        tbl.push_back(mk(7'b0100000, 6'b000010));
        tbl.push_back(mk(7'b0110000, 6'b000010));
        tbl.push_back(mk(7'b0100100, 6'b000110));
        tbl.push_back(mk(7'b0000000, 6'b000000));

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].in);
            check($sformatf("vec[%0d]", i), int'(outs()), int'(tbl[i].exp));
        end

        // No badge: DECIDE after exactly BW wait cycles, entry as visitor
        tick(7'b0100010);
        for (int k = 1; k <= BW; k++) tick(7'b0100010);
        check("nobadge_closed_at_bw", int'(outs()), int'(6'b000010));
        tick(7'b0100010);
        check("nobadge_open_at_bw+1", int'(outs()), int'(6'b100010));
        tick(7'b0000001);
        tick(7'b0000000);
        check("nobadge_entry_visitor", int'(outs()), int'(6'b010010));
        tick(7'b0000000);
        check("nobadge_idle", int'(outs()), int'(6'b000000));

        // Badge arrives on the timer-expiry cycle: classed uni
        tick(7'b0100100);
        for (int k = 1; k < BW; k++) tick(7'b0100100);
        tick(7'b0111100);
        tick(7'b0100100);
        check("expiry_badge_opens", int'(outs()), int'(6'b100010));
        tick(7'b0000001);
        tick(7'b0000000);
        check("expiry_badge_uni_entry", int'(outs()), int'(6'b011010));
        tick(7'b0000000);

        // Barrier open with no pass
        tick(7'b0100100);
        tick(7'b0111100);
        tick(7'b0100100);
        check("open_start", int'(outs()), int'(6'b100010));
`ifdef PARKING_GATE_TIMEOUT_EN
        for (int k = 1; k < OT; k++) tick(7'b0100100);
        check("open_before_timeout", int'(outs()), int'(6'b100010));
        tick(7'b0100100);
        check("timeout_pulse", int'(outs()), int'(6'b000011));
        tick(7'b0100100);
        check("timeout_wait", int'(outs()), int'(6'b000010));
        tick(7'b0000000);
        check("timeout_idle", int'(outs()), int'(6'b000000));
`else
        for (int k = 1; k <= OT + 5; k++) tick(7'b0100100);
        check("open_no_timeout", int'(outs()), int'(6'b100010));
        tick(7'b0000001);
        tick(7'b0000000);
        check("open_late_entry", int'(outs()), int'(6'b011010));
        tick(7'b0000000);
`endif

        // Randomized vehicles against a transaction-level outcome model
        for (int n = 0; n < 40; n++) begin
            int  bd, lv, pl, dec, last, e0, r0;
            bit  leave, bu, uv, vv, cls, flag, left_early, exp_ent, exp_rej;
            bd    = int'($urandom_range(1, BW + 3));
            leave = ($urandom_range(0, 3) == 0);
            lv    = int'($urandom_range(1, BW));
            bu    = 1'($urandom_range(0, 1));
            uv    = 1'($urandom_range(0, 1));
            vv    = 1'($urandom_range(0, 1));
            pl    = int'($urandom_range(1, 4));

            // A car that is gone by the decision cycle yields no pulses;
            // otherwise the class is the badge (or visitor) and the matching flag decides.
            dec        = (bd <= BW) ? bd : BW;
            left_early = leave && (lv <= dec);
            cls        = (bd <= BW) ? bu : 1'b0;
            flag       = cls ? uv : vv;
            exp_ent    = !left_early && flag;
            exp_rej    = !left_early && !flag;
            last       = left_early ? lv : dec;

            e0 = ent_cnt;
            r0 = rej_cnt;
            tick({1'b0, 1'b1, 1'b0, 1'b0, uv, vv, 1'b0});
            for (int k = 1; k <= last; k++)
                tick({1'b0, !(leave && k >= lv), (k == bd), bu, uv, vv, 1'b0});
            if (!left_early) begin
                tick({1'b0, 1'b1, 1'b0, 1'b0, uv, vv, 1'b0});
                if (flag) begin
                    check($sformatf("rnd[%0d]_barrier", n), int'(barrier_open), 1);
                    for (int p = 0; p < pl; p++) tick({1'b0, 1'b1, 1'b0, 1'b0, uv, vv, 1'b1});
                    tick(7'b0000000);
                    tick(7'b0000000);
                end else begin
                    tick({1'b0, 1'b1, 1'b0, 1'b0, uv, vv, 1'b0});
                    tick(7'b0000000);
                end
            end
            tick(7'b0000000);
            check($sformatf("rnd[%0d]_entered", n), ent_cnt - e0, int'(exp_ent));
            check($sformatf("rnd[%0d]_reject", n), rej_cnt - r0, int'(exp_rej));
            if (exp_ent) check($sformatf("rnd[%0d]_class", n), int'(ent_uni), int'(cls));
            check($sformatf("rnd[%0d]_idle", n), int'({busy, barrier_open}), 0);
        end

        check("stray_is_uni", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
